// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared BIST defaults and response-analyzer state encoding
package bist_pkg;

    localparam int          W        = 16;
    localparam logic [15:0] POLY     = 16'h1021;
    localparam logic [15:0] SEED     = 16'hFFFF;
    localparam int          NSAMPLES = 650;

    typedef logic [2:0] bist_state_t;

    localparam bist_state_t ST_IDLE    = 3'd0;
    localparam bist_state_t ST_ARMED   = 3'd1;
    localparam bist_state_t ST_COLLECT = 3'd2;
    localparam bist_state_t ST_CHECK   = 3'd3;
    localparam bist_state_t ST_DONE    = 3'd4;

    // States in which a running cycle delivers a CUT response worth compacting
    function automatic logic state_accepts_samples(input bist_state_t st);
        return (st == ST_ARMED) || (st == ST_COLLECT);
    endfunction

endpackage

// File: rtl/bist_misr.sv
// rtl/bist_misr.sv - multiple-input signature register, Galois-style shift with XOR-in of data
module bist_misr #(
    parameter int         W    = 16,
    parameter logic [W-1:0] POLY = 16'h1021
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] seed,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] sig
);

    logic [W-1:0] sig_next;

    always_comb begin
        sig_next = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ din;
    end

    // load wins over en so a reseed never absorbs a stray sample
    always_ff @(posedge clk) begin
        if (load) begin
            sig <= seed;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/bist_response_analyzer.sv
// rtl/bist_response_analyzer.sv - BIST response analyzer; BIST_SAMPLE_CHECK_EN also requires the exact sample count to pass
module bist_response_analyzer #(
    parameter int           W        = bist_pkg::W,
    parameter logic [W-1:0] POLY     = bist_pkg::POLY,
    parameter logic [W-1:0] SEED     = bist_pkg::SEED,
    parameter logic [W-1:0] GOLDEN   = '0,
    parameter int           NSAMPLES = bist_pkg::NSAMPLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          init,
    input  logic                          running,
    input  logic                          finish,
    input  logic [W-1:0]                  cut_data,
    output logic [W-1:0]                  signature,
    output logic [$clog2(NSAMPLES):0]     sample_count,
    output logic                          done,
    output logic                          pass
);

    import bist_pkg::*;

    localparam int CW = $clog2(NSAMPLES) + 1;

    bist_state_t state;
    logic        misr_load;
    logic        misr_en;
    logic        sig_match;
    logic        count_full;

    assign count_full = (sample_count == {CW{1'b1}});
    assign misr_load  = reset | init;
    // finish and init both pre-empt the sample presented in the same cycle
    assign misr_en    = state_accepts_samples(state) & running & ~finish & ~init & ~reset;

`ifdef BIST_SAMPLE_CHECK_EN
    assign sig_match = (signature == GOLDEN) && (sample_count == CW'(NSAMPLES));
`else
    assign sig_match = (signature == GOLDEN);
`endif

    bist_misr #(
        .W    (W),
        .POLY (POLY)
    ) u_misr (
        .clk  (clk),
        .load (misr_load),
        .seed (SEED),
        .en   (misr_en),
        .din  (cut_data),
        .sig  (signature)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            sample_count <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else if (init) begin
            state        <= ST_ARMED;
            sample_count <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            case (state)
                ST_ARMED, ST_COLLECT: begin
                    if (finish) begin
                        state <= ST_CHECK;
                    end else if (running) begin
                        state <= ST_COLLECT;
                        if (!count_full) begin
                            sample_count <= sample_count + 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    done  <= 1'b1;
                    pass  <= sig_match;
                    state <= ST_DONE;
                end
                ST_IDLE, ST_DONE: begin
                    state <= state;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_response_analyzer.sv
// tb/tb_bist_response_analyzer.sv - directed scoreboard bench for bist_response_analyzer
module tb_bist_response_analyzer;

    logic        clk = 1'b0;
    logic        reset;
    logic        init;
    logic        running;
    logic        finish;
    logic [15:0] cut_data;

    logic [15:0] sig_a, sig_b, sig_c;
    logic [0:0]  cnt_a;
    logic [10:0] cnt_b, cnt_c;
    logic        done_a, done_b, done_c;
    logic        pass_a, pass_b, pass_c;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] sb[$];
    logic [15:0] model;
    logic        exp_pass;

`ifdef BIST_SAMPLE_CHECK_EN
    localparam bit SAMPLE_CHECK = 1'b1;
`else
    localparam bit SAMPLE_CHECK = 1'b0;
`endif

    always #5 clk = ~clk;

    bist_response_analyzer #(.SEED(16'h0001), .GOLDEN(16'h0002), .NSAMPLES(1)) dut_a (
        .clk(clk), .reset(reset), .init(init), .running(running), .finish(finish),
        .cut_data(cut_data), .signature(sig_a), .sample_count(cnt_a), .done(done_a), .pass(pass_a));

    bist_response_analyzer #(.SEED(16'h0000), .GOLDEN(16'h0000), .NSAMPLES(650)) dut_b (
        .clk(clk), .reset(reset), .init(init), .running(running), .finish(finish),
        .cut_data(cut_data), .signature(sig_b), .sample_count(cnt_b), .done(done_b), .pass(pass_b));

    bist_response_analyzer dut_c (
        .clk(clk), .reset(reset), .init(init), .running(running), .finish(finish),
        .cut_data(cut_data), .signature(sig_c), .sample_count(cnt_c), .done(done_c), .pass(pass_c));

    function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [15:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        init = 1'b0; running = 1'b0; finish = 1'b0; cut_data = 16'h0000;
    endtask

    task automatic pulse_init();
        init = 1'b1; tick(); init = 1'b0;
    endtask

    // Random samples into dut_c; each expected signature is queued at drive time and popped once the edge has passed
    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            running  = 1'b1;
            cut_data = 16'($urandom);
            model    = misr_ref(model, cut_data);
            sb.push_back(model);
            tick();
            check("c_sig_step", sig_c, sb.pop_front());
        end
        running = 1'b0;
    endtask

    task automatic run_zero(input int n);
        for (int i = 0; i < n; i++) begin
            running = 1'b1; cut_data = 16'h0000; tick();
        end
        running = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("rst_sig_c", sig_c, 16'hFFFF);
        check("rst_cnt_c", cnt_c, 0);
        check("rst_done_c", done_c, 0);
        check("rst_pass_c", pass_c, 0);
        check("rst_sig_a", sig_a, 16'h0001);

        // running / finish with no init are ignored
        for (int i = 0; i < 4; i++) begin
            running = (i != 1); finish = (i != 0); cut_data = 16'h1234;
            tick();
            check("noinit_sig", sig_c, 16'hFFFF);
            check("noinit_cnt", cnt_c, 0);
            check("noinit_done", done_c, 0);
            check("noinit_pass", pass_c, 0);
        end
        idle_inputs();
        tick();
        check("noinit_done_late", done_c, 0);

        // single zero sample from seed 1
        pulse_init();
        check("s1_seed", sig_a, 16'h0001);
        running = 1'b1; cut_data = 16'h0000; tick(); running = 1'b0;
        check("s1_sig", sig_a, 16'h0002);
        check("s1_cnt", cnt_a, 1);
        finish = 1'b1; tick(); finish = 1'b0;
        check("s1_done_check", done_a, 0);
        tick();
        check("s1_done", done_a, 1);
        check("s1_pass", pass_a, 1);
        running = 1'b1; cut_data = 16'hFFFF; tick(); running = 1'b0;
        check("s1_done_hold_sig", sig_a, 16'h0002);
        check("s1_done_hold", done_a, 1);

        // single sample of 4 -> mismatch
        pulse_init();
        check("s3_done_clr", done_a, 0);
        running = 1'b1; cut_data = 16'h0004; tick(); running = 1'b0;
        finish = 1'b1; tick(); finish = 1'b0;
        tick();
        check("s3_sig", sig_a, 16'h0006);
        check("s3_done", done_a, 1);
        check("s3_pass", pass_a, 0);

        // 650 zero samples from seed 0
        pulse_init();
        run_zero(650);
        check("s2_sig", sig_b, 16'h0000);
        check("s2_cnt", cnt_b, 650);
        check("s2_cnt_sat_a", cnt_a, 1);
        finish = 1'b1; tick(); finish = 1'b0;
        tick();
        check("s2_done", done_b, 1);
        check("s2_pass", pass_b, 1);

        pulse_init();
        run_zero(649);
        finish = 1'b1; tick(); finish = 1'b0;
        tick();
        check("s2_cnt649", cnt_b, 649);
        check("s2_pass649", pass_b, !SAMPLE_CHECK);

        // reset in the middle of a run
        pulse_init();
        model = 16'hFFFF;
        run_random(299);
        reset = 1'b1; running = 1'b1; cut_data = 16'hA5A5; tick();
        reset = 1'b0; running = 1'b0;
        check("s5_sig", sig_c, 16'hFFFF);
        check("s5_cnt", cnt_c, 0);
        check("s5_done", done_c, 0);
        check("s5_pass", pass_c, 0);
        finish = 1'b1; tick(); finish = 1'b0;
        tick(); tick();
        check("s5_fin_ignored", done_c, 0);
        check("s5_sig_hold", sig_c, 16'hFFFF);

        // init mid-collect, then a clean full run
        pulse_init();
        model = 16'hFFFF;
        run_random(100);
        init = 1'b1; running = 1'b1; cut_data = 16'h5A5A; tick();
        init = 1'b0; running = 1'b0;
        check("s6_reinit_sig", sig_c, 16'hFFFF);
        check("s6_reinit_cnt", cnt_c, 0);
        model = 16'hFFFF;
        run_random(650);
        check("s6_cnt", cnt_c, 650);
        finish = 1'b1; tick(); finish = 1'b0;
        tick();
        check("s6_done", done_c, 1);
        check("s6_pass", pass_c, (model == 16'h0000));

        // last sample collides with finish and is dropped
        pulse_init();
        model = 16'hFFFF;
        run_random(649);
        running = 1'b1; finish = 1'b1; cut_data = 16'h0F0F; tick();
        running = 1'b0; finish = 1'b0;
        check("s6_excl_sig", sig_c, model);
        check("s6_excl_cnt", cnt_c, 649);
        tick();
        exp_pass = (model == 16'h0000) && !SAMPLE_CHECK;
        check("s6_excl_done", done_c, 1);
        check("s6_excl_pass", pass_c, exp_pass);
        check("s6_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
